// File: rtl/ps2_key_rx.sv
// rtl/ps2_key_rx.sv - PS/2 keyboard frame receiver with prefix decoding and character FIFO
module ps2_key_rx #(
  parameter int CHAR_W      = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps2_clk,
  input  logic              ps2_dat,
  output logic [CHAR_W-1:0] char_o,
  output logic              char_valid_o,
  input  logic              char_ready_i,
  output logic              parity_err_o,
  output logic              overflow_o
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FILTER_LEN + 1);
  localparam int TMR_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic              r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic              r_clk_filt;
  logic [FCNT_W-1:0] r_filt_cnt;
  logic              w_fall;

  state_t            r_state;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic              r_par_bit;
  logic [TMR_W-1:0]  r_timer;
  logic              r_done, r_ok;
  logic              r_ext, r_brk;

  logic [CHAR_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W:0]    r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]    w_wr_ptr_n, w_rd_ptr_n;
  logic              w_push, w_pop, w_full, w_wr_en;
  logic [CHAR_W-1:0] w_din, w_head_n;

  // Two-flop synchronisers; idle PS/2 lines are high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_dat;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Glitch filter: follow the synchronised clock only after a run of FILTER_LEN differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_filt_cnt <= '0;
      r_clk_filt <= 1'b1;
    end else if (r_clk_s2 == r_clk_filt) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == FCNT_W'(FILTER_LEN - 1)) begin
      r_clk_filt <= r_clk_s2;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + FCNT_W'(1);
    end
  end

  // Falling edge is the cycle the filtered clock is about to drop
  assign w_fall = r_clk_filt && !r_clk_s2 && (r_filt_cnt == FCNT_W'(FILTER_LEN - 1));

  // Frame FSM: start, 8 data bits LSB first, odd parity, stop; inactivity timeout aborts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_bit    <= 1'b0;
      r_timer      <= '0;
      r_done       <= 1'b0;
      r_ok         <= 1'b0;
      parity_err_o <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      parity_err_o <= 1'b0;
      if (r_state == S_IDLE || w_fall) r_timer <= '0;
      else                             r_timer <= r_timer + TMR_W'(1);
      case (r_state)
        S_IDLE: begin
          if (w_fall && !r_dat_s2) begin
            r_state   <= S_DATA;
            r_bit_cnt <= '0;
          end
        end
        S_DATA: begin
          if (w_fall) begin
            r_shift   <= {r_dat_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
          end
        end
        S_PARITY: begin
          if (w_fall) begin
            r_par_bit <= r_dat_s2;
            r_state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_fall) begin
            r_state      <= S_IDLE;
            r_done       <= 1'b1;
            r_ok         <= r_dat_s2 && (^{r_par_bit, r_shift});
            parity_err_o <= !(r_dat_s2 && (^{r_par_bit, r_shift}));
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (r_state != S_IDLE && !w_fall && r_timer == TMR_W'(TIMEOUT_CYC - 1)) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= '0;
      end
    end
  end

  assign w_push = r_done && r_ok && (r_shift != 8'hE0) && (r_shift != 8'hF0);
  assign w_din  = CHAR_W'({r_brk, r_ext, r_shift});

  // Prefix flags: E0 marks extended, F0 marks break; consumed by the next pushed byte or a bad frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (r_done) begin
      if (r_ok && r_shift == 8'hE0) begin
        r_ext <= 1'b1;
      end else if (r_ok && r_shift == 8'hF0) begin
        r_brk <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

  assign w_full     = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                      (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_pop      = char_valid_o && char_ready_i;
  assign w_wr_en    = w_push && (!w_full || w_pop);
  assign w_wr_ptr_n = w_wr_en ? r_wr_ptr + (PTR_W+1)'(1) : r_wr_ptr;
  assign w_rd_ptr_n = w_pop   ? r_rd_ptr + (PTR_W+1)'(1) : r_rd_ptr;
  // A write landing on the next head slot only happens when the FIFO drains to empty
  assign w_head_n   = (w_wr_en && r_wr_ptr[PTR_W-1:0] == w_rd_ptr_n[PTR_W-1:0]) ?
                      w_din : r_mem[w_rd_ptr_n[PTR_W-1:0]];

  // FIFO storage
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[PTR_W-1:0]] <= w_din;
  end

  // FIFO pointers and registered head/valid/overflow outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      char_o       <= '0;
      char_valid_o <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      r_wr_ptr     <= w_wr_ptr_n;
      r_rd_ptr     <= w_rd_ptr_n;
      char_valid_o <= (w_rd_ptr_n != w_wr_ptr_n);
      char_o       <= (w_rd_ptr_n != w_wr_ptr_n) ? w_head_n : '0;
      if (w_push && w_full && !w_pop) overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_key_rx.sv
// tb/tb_ps2_key_rx.sv - self-checking bench for ps2_key_rx against a frame-level reference model
module tb_ps2_key_rx;
  localparam int CW    = 16;
  localparam int DEPTH = 4;
  localparam int FL    = 4;
  localparam int TO    = 300;
  localparam int H     = 20;

  logic          clk = 1'b0;
  logic          rst, ps2_clk, ps2_dat, ready;
  logic [CW-1:0] char_o;
  logic          char_valid_o, parity_err_o, overflow_o;

  ps2_key_rx #(.CHAR_W(CW), .FIFO_DEPTH(DEPTH), .FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .char_o(char_o), .char_valid_o(char_valid_o), .char_ready_i(ready),
    .parity_err_o(parity_err_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_q[$];
  bit m_ext, m_brk, m_ovf;
  int exp_perr = 0;
  int perr_seen = 0;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model: one decoded frame at a time, FIFO as a bounded queue
  task automatic model_frame(input logic [7:0] b, input bit ok);
    logic [CW-1:0] c;
    if (!ok) begin
      m_ext = 0; m_brk = 0; exp_perr++;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      c = CW'(b) + (m_ext ? CW'(256) : CW'(0)) + (m_brk ? CW'(512) : CW'(0));
      if (exp_q.size() < DEPTH) exp_q.push_back(c);
      else m_ovf = 1;
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] bits;
    logic par;
    par  = (~^b) ^ bad_par;
    bits = {~bad_stop, par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_dat = bits[i];
      cyc(H);
      if (i == 10) model_frame(b, !bad_par && !bad_stop);
      ps2_clk = 1'b0;
      cyc(H);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    cyc(H);
  endtask

  task automatic partial(input int nbits);
    for (int i = 0; i <= nbits; i++) begin
      ps2_dat = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      cyc(H);
      ps2_clk = 1'b0;
      cyc(H);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic step_end(input string tag);
    cyc(40);
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_valid"}, char_valid_o, 1'b0);
    chk({tag, "_perr_count"}, perr_seen, exp_perr);
    chk({tag, "_overflow"}, overflow_o, m_ovf);
  endtask

  // Consumer monitor: every accepted character must be the model's next one
  always @(negedge clk) begin
    if (!rst && char_valid_o === 1'b1 && ready === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL extra_char observed=%0h expected=none", char_o);
      end
      if (exp_q.size() != 0) begin
        checks++;
        assert (char_o === exp_q[0]) else begin
          errors++;
          $error("FAIL char observed=%0h expected=%0h", char_o, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
    if (!rst && parity_err_o === 1'b1) perr_seen++;
  end

  initial begin
    logic [7:0] rb;
    rst = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; ready = 1'b1;
    cyc(5);
    chk("reset_char", char_o, 0);
    chk("reset_valid", char_valid_o, 0);
    chk("reset_perr", parity_err_o, 0);
    chk("reset_ovf", overflow_o, 0);
    rst = 1'b0;
    cyc(10);

    send_frame(8'h1C, 0, 0);
    step_end("single_1c");

    send_frame(8'hF0, 0, 0); send_frame(8'h1C, 0, 0);
    send_frame(8'hE0, 0, 0); send_frame(8'h75, 0, 0);
    send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h75, 0, 0);
    step_end("prefixes");

    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 1, 0);
    step_end("bad_parity");
    send_frame(8'h1C, 0, 0);
    step_end("after_bad_parity");
    send_frame(8'h33, 0, 1);
    step_end("bad_stop");

    partial(4);
    cyc(2 * TO);
    send_frame(8'h29, 0, 0);
    step_end("timeout");

    ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 0);
    cyc(20);
    chk("full_valid", char_valid_o, 1'b1);
    chk("full_head", char_o, 16'h0001);
    chk("full_ovf", overflow_o, 1'b1);
    cyc(30);
    chk("full_head_stable", char_o, 16'h0001);
    ready = 1'b1;
    step_end("overflow");

    send_frame(8'hE0, 0, 0);
    partial(3);
    cyc(3);
    rst = 1'b1;
    m_ext = 0; m_brk = 0; m_ovf = 0;
    cyc(3);
    chk("midrst_ovf", overflow_o, 0);
    chk("midrst_valid", char_valid_o, 0);
    rst = 1'b0;
    cyc(5);
    send_frame(8'h5A, 0, 0);
    step_end("mid_reset");
    chk("mid_reset_perr_pin", parity_err_o, 0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0:       rb = 8'hE0;
        1:       rb = 8'hF0;
        default: rb = 8'($urandom_range(0, 255));
      endcase
      ready = ($urandom_range(0, 3) != 0);
      send_frame(rb, ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
    end
    ready = 1'b1;
    step_end("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_key_rx.md
PS2_KEY_RX -- requirements
Module: ps2_key_rx

Interface
REQ-001 SHALL have parameter CHAR_W, default 16, meaning the output character width (legal range 10 or more).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning the number of character FIFO entries (power of 2, 2 or more).
REQ-003 SHALL have parameter FILTER_LEN, default 4, meaning the number of consecutive equal synchronised samples needed to accept a ps2_clk level change.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 5000, meaning the number of clk cycles without a filtered ps2_clk falling edge that aborts a partial frame.
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 ps2_clk  input  1  PS/2 clock from the device, asynchronous to clk.
REQ-008 ps2_dat  input  1  PS/2 data from the device, asynchronous to clk.
REQ-009 char_o  output  CHAR_W  FIFO head character; bits [7:0] scan code, bit 8 extended, bit 9 break, upper bits 0.
REQ-010 char_valid_o  output  1  high when the FIFO is non-empty.
REQ-011 char_ready_i  input  1  consumer accepts char_o on a cycle where char_valid_o && char_ready_i.
REQ-012 parity_err_o  output  1  one-cycle pulse per frame discarded for bad parity or bad stop bit.
REQ-013 overflow_o  output  1  sticky flag, set when a character is dropped because the FIFO is full.

Function
REQ-014 ps2_clk and ps2_dat SHALL each pass a 2-flop synchroniser; filtered ps2_clk SHALL change only after FILTER_LEN consecutive equal synchronised samples.
REQ-015 A bit SHALL be sampled from synchronised ps2_dat in the cycle a filtered ps2_clk falling edge is detected.
REQ-016 The frame FSM SHALL use states IDLE, DATA, PARITY and STOP, with transitions as follows.
  - IDLE to DATA on a sampled 0 (start bit); a sampled 1 stays in IDLE.
  - DATA to PARITY after 8 bits, received LSB first.
  - PARITY to STOP after 1 bit.
  - STOP to IDLE after 1 bit.
REQ-017 A frame SHALL be valid only if the parity bit makes the 9 bits odd-parity and the stop bit is 1.
REQ-018 An invalid frame SHALL be discarded, pulse parity_err_o in the cycle after the stop bit is sampled, and clear both prefix flags.
REQ-019 In DATA, PARITY or STOP, TIMEOUT_CYC cycles without a falling edge SHALL return the FSM to IDLE, discard partial bits, and leave prefix flags unchanged; no error pulse.
REQ-020 A valid byte 0xE0 SHALL set the ext flag and a valid byte 0xF0 SHALL set the brk flag; neither SHALL be pushed.
REQ-021 Any other valid byte SHALL be pushed as {0, brk, ext, byte}, with both flags cleared in the same cycle.
REQ-022 The push SHALL occur in the cycle after the stop bit is sampled; char_valid_o SHALL be high from the following cycle if the FIFO was empty.
REQ-023 char_o SHALL be the registered FIFO head, stable while char_valid_o && !char_ready_i.
REQ-024 A pop SHALL occur on char_valid_o && char_ready_i; char_ready_i SHALL be ignored when the FIFO is empty.
REQ-025 A push while full with no pop in the same cycle SHALL drop the new character, leave FIFO contents unchanged, and set overflow_o.
REQ-026 A push and a pop in the same cycle SHALL both take effect at any occupancy, including full, with no overflow.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked with one extra pointer bit.

Reset
REQ-028 rst high SHALL immediately force the following, regardless of a frame in progress:
  - FSM to IDLE, bit counter to 0;
  - ext/brk flags, FIFO pointers and filter counters to 0;
  - filtered ps2_clk to 1;
  - char_o = 0, char_valid_o = 0, parity_err_o = 0, overflow_o = 0.
REQ-029 After rst deasserts, the block SHALL wait for a fresh start bit; bits of an interrupted frame SHALL never be emitted.

Verification
REQ-030 Frame 0x1C with correct parity, ready high -> char_o = 0x001C with valid for exactly 1 cycle.
REQ-031 Frames F0,1C then E0,75 then E0,F0,75 -> characters 0x021C, 0x0175, 0x0375 in order, with no extra entries.
REQ-032 Frame 0x1C with the parity bit flipped -> one parity_err_o pulse and no push; then frame 0x1C -> 0x001C with no stale flags.
REQ-033 FIFO_DEPTH=4, ready low, 5 frames 0x01..0x05 -> 4 entries 0x0001..0x0004 and overflow_o=1; with ready high, pop sequence 01,02,03,04, then valid=0.
REQ-034 Start bit plus 4 data bits, then idle for 2*TIMEOUT_CYC cycles, then full frame 0x29 -> only 0x0029 output.
REQ-035 rst asserted mid-DATA, then a full frame 0x5A -> only 0x005A output, with overflow_o and parity_err_o at 0.
